// File: rtl/clk_switch_seq_if.sv
// rtl/clk_switch_seq_if.sv - request/completion handshake bundle for the clock-switch sequencer
//
// Signals:
//   req_valid  requester -> sequencer   switch request valid (held until accepted)
//   req_sel    requester -> sequencer   requested mux input (0 = I0, 1 = I1)
//   req_ready  sequencer -> requester   high only while the sequencer is idle
//   busy       sequencer -> requester   high in every non-idle state
//   done       sequencer -> requester   one-cycle completion pulse
//   done_err   sequencer -> requester   qualifies done: heartbeat timeout, selection reverted
interface clk_switch_seq_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic busy;
  logic done;
  logic done_err;

  modport master (
    output req_valid, req_sel,
    input  req_ready, busy, done, done_err
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, busy, done, done_err
  );
endinterface

// File: rtl/clk_switch_seq.sv
// rtl/clk_switch_seq.sv - break-before-make sequencer for a two-input glitch-free clock mux
//
// Ports:
//   clk       always-on control clock
//   reset     asynchronous active-high reset (released synchronously upstream)
//   req       request/completion handshake (slave side)
//   hb0, hb1  heartbeat toggles from the two source clock domains (asynchronous)
//   ce0, s0   mux enable/select for input 0 (registered, always equal)
//   ce1, s1   mux enable/select for input 1 (registered, always equal)
//   cur_sel   input currently driving the mux output
module clk_switch_seq #(
  parameter bit INIT_SEL       = 1'b0,
  parameter int DRAIN_CYCLES   = 4,
  parameter int HB_EDGES       = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  clk_switch_seq_if.slave    req,
  input  logic               hb0,
  input  logic               hb1,
  output logic               ce0,
  output logic               s0,
  output logic               ce1,
  output logic               s1,
  output logic               cur_sel
);

  localparam int MAX_DT  = (DRAIN_CYCLES > TIMEOUT_CYCLES) ? DRAIN_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_DT > SETTLE_CYCLES) ? MAX_DT : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int EW      = $clog2(HB_EDGES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_DRAIN,
    ST_WAIT_HB,
    ST_SELECT,
    ST_REVERT,
    ST_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [EW-1:0] ecnt, ecnt_d;
  logic [EW-1:0] ecnt_inc;
  logic          en0, en0_d;
  logic          en1, en1_d;
  logic          cur_q, cur_d;
  logic          tgt, tgt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [1:0]    hb0_sync, hb1_sync;
  logic          hb0_dly, hb1_dly;
  logic          edge0, edge1, tgt_edge;

  // One enable bit per pair drives both s and ce, so the pair can never split.
  assign ce0 = en0;
  assign s0  = en0;
  assign ce1 = en1;
  assign s1  = en1;
  assign cur_sel = cur_q;

  assign req.req_ready = (state == ST_IDLE);
  assign req.busy      = (state != ST_IDLE);
  assign req.done      = done_q;
  assign req.done_err  = err_q;

  assign edge0    = hb0_sync[1] ^ hb0_dly;
  assign edge1    = hb1_sync[1] ^ hb1_dly;
  assign tgt_edge = tgt ? edge1 : edge0;
  assign ecnt_inc = ecnt + EW'(tgt_edge);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb0_sync <= 2'b00;
      hb1_sync <= 2'b00;
      hb0_dly  <= 1'b0;
      hb1_dly  <= 1'b0;
    end else begin
      hb0_sync <= {hb0_sync[0], hb0};
      hb1_sync <= {hb1_sync[0], hb1};
      hb0_dly  <= hb0_sync[1];
      hb1_dly  <= hb1_sync[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ecnt   <= '0;
      en0    <= ~INIT_SEL;
      en1    <= INIT_SEL;
      cur_q  <= INIT_SEL;
      tgt    <= INIT_SEL;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ecnt   <= ecnt_d;
      en0    <= en0_d;
      en1    <= en1_d;
      cur_q  <= cur_d;
      tgt    <= tgt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ecnt_d  = ecnt;
    en0_d   = en0;
    en1_d   = en1;
    cur_d   = cur_q;
    tgt_d   = tgt;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (req.req_valid) begin
          tgt_d = req.req_sel;
          if (req.req_sel == cur_q) begin
            state_d = ST_ACK;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            en0_d   = 1'b0;
            en1_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      ST_ACK: state_d = ST_IDLE;

      ST_DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_WAIT_HB;
          cnt_d   = '0;
          ecnt_d  = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_WAIT_HB: begin
        // A heartbeat edge on the final timeout cycle still counts.
        if (tgt_edge && (ecnt_inc == EW'(HB_EDGES))) begin
          state_d = ST_SELECT;
          cnt_d   = '0;
          en0_d   = ~tgt;
          en1_d   = tgt;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_REVERT;
          en0_d   = ~cur_q;
          en1_d   = cur_q;
        end else begin
          cnt_d  = cnt + 1'b1;
          ecnt_d = ecnt_inc;
        end
      end

      ST_SELECT: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_DONE;
          cur_d   = tgt;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_REVERT: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_switch_seq.sv
// tb/tb_clk_switch_seq.sv - self-checking bench for the clock-switch sequencer
module tb_clk_switch_seq;

  typedef struct {
    bit err;
    bit sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hb0 = 1'b0;
  logic hb1 = 1'b0;
  logic ce0, s0, ce1, s1, cur_sel;
  bit   hb0_run = 1'b0;
  bit   hb1_run = 1'b0;
  int   hb_div = 0;

  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  int   n_accept = 0;
  bit   model_cur = 1'b0;
  exp_t sb[$];

  clk_switch_seq_if req_if ();

  clk_switch_seq #(
    .INIT_SEL(1'b0),
    .DRAIN_CYCLES(4),
    .HB_EDGES(2),
    .TIMEOUT_CYCLES(256),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req_if.slave),
    .hb0(hb0),
    .hb1(hb1),
    .ce0(ce0),
    .s0(s0),
    .ce1(ce1),
    .s1(s1),
    .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  // Heartbeats toggle every 3 control clocks while enabled.
  always @(posedge clk) begin
    if (hb_div == 2) begin
      hb_div <= 0;
      if (hb0_run) hb0 <= ~hb0;
      if (hb1_run) hb1 <= ~hb1;
    end else begin
      hb_div <= hb_div + 1;
    end
  end

  // Invariants and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    checks++;
    if ((s0 & s1) !== 1'b0 || (ce0 & ce1) !== 1'b0) begin
      errors++;
      $display("FAIL overlap: s0=%b s1=%b ce0=%b ce1=%b expected no overlap", s0, s1, ce0, ce1);
    end
    checks++;
    if (ce0 !== s0 || ce1 !== s1) begin
      errors++;
      $display("FAIL pair_split: ce0=%b s0=%b ce1=%b s1=%b expected pairs equal", ce0, s0, ce1, s1);
    end
    checks++;
    if (req_if.req_ready !== ~req_if.busy) begin
      errors++;
      $display("FAIL ready_busy: req_ready=%b busy=%b expected complementary", req_if.req_ready, req_if.busy);
    end
    if (req_if.done === 1'b1) begin
      exp_t e;
      n_done++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 expected no done");
      end else begin
        e = sb.pop_front();
        if (req_if.done_err !== e.err || cur_sel !== e.sel) begin
          errors++;
          $display("FAIL sb_done: got done_err=%b cur_sel=%b expected done_err=%b cur_sel=%b",
                   req_if.done_err, cur_sel, e.err, e.sel);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit sel, input bit exp_err, input bit exp_sel);
    exp_t e;
    checks++;
    if (req_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got req_ready=%b expected 1", req_if.req_ready);
    end
    req_if.req_valid = 1'b1;
    req_if.req_sel   = sel;
    tick();
    req_if.req_valid = 1'b0;
    e.err = exp_err;
    e.sel = exp_sel;
    sb.push_back(e);
    n_accept++;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (req_if.done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (req_if.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic test_reset();
    req_if.req_valid = 1'b0;
    req_if.req_sel   = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({ce0, s0, ce1, s1, cur_sel} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: got ce0s0ce1s1cur=%b expected 11000", {ce0, s0, ce1, s1, cur_sel});
    end
    checks++;
    if ({req_if.req_ready, req_if.busy, req_if.done, req_if.done_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hs: got ready,busy,done,err=%b expected 1000",
               {req_if.req_ready, req_if.busy, req_if.done, req_if.done_err});
    end
  endtask

  task automatic test_same_sel();
    accept(1'b0, 1'b0, 1'b0);
    checks++;
    if (req_if.done !== 1'b1 || req_if.done_err !== 1'b0) begin
      errors++;
      $display("FAIL same_done: got done=%b err=%b expected 1 0", req_if.done, req_if.done_err);
    end
    checks++;
    if ({ce0, ce1} !== 2'b10) begin
      errors++;
      $display("FAIL same_ctrl: got ce0ce1=%b expected 10", {ce0, ce1});
    end
    tick();
    checks++;
    if (req_if.done !== 1'b0 || req_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_after: got done=%b ready=%b expected 0 1", req_if.done, req_if.req_ready);
    end
  endtask

  task automatic test_timeout();
    int low = 0;
    bit ce1_seen = 1'b0;
    hb1_run = 1'b0;
    accept(1'b1, 1'b1, 1'b0);
    while (ce0 === 1'b0 && low < 400) begin
      if (ce1 !== 1'b0) ce1_seen = 1'b1;
      low++;
      tick();
    end
    checks++;
    if (low != 260) begin
      errors++;
      $display("FAIL timeout_low: got %0d low cycles expected 260", low);
    end
    checks++;
    if (ce1_seen || req_if.done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_revert: got ce1_seen=%b done=%b expected 0 0", ce1_seen, req_if.done);
    end
    tick();
    checks++;
    if (req_if.done !== 1'b1 || req_if.done_err !== 1'b1 || cur_sel !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: got done=%b err=%b cur=%b expected 1 1 0",
               req_if.done, req_if.done_err, cur_sel);
    end
    tick();
  endtask

  task automatic test_switch();
    int low = 0;
    int settle = 0;
    hb1_run = 1'b1;
    accept(1'b1, 1'b0, 1'b1);
    checks++;
    if (ce0 !== 1'b0 || req_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL switch_drop: got ce0=%b busy=%b expected 0 1", ce0, req_if.busy);
    end
    while (ce0 === 1'b0 && ce1 === 1'b0 && low < 100) begin
      low++;
      tick();
    end
    checks++;
    if (low < 5 || low > 12 || ce1 !== 1'b1) begin
      errors++;
      $display("FAIL switch_gap: got %0d low cycles ce1=%b expected 5..12 and ce1=1", low, ce1);
    end
    while (req_if.done !== 1'b1 && settle < 20) begin
      settle++;
      tick();
    end
    checks++;
    if (settle != 4) begin
      errors++;
      $display("FAIL switch_settle: got %0d cycles expected 4", settle);
    end
    checks++;
    if (cur_sel !== 1'b1 || req_if.done_err !== 1'b0) begin
      errors++;
      $display("FAIL switch_done: got cur=%b err=%b expected 1 0", cur_sel, req_if.done_err);
    end
    tick();
    model_cur = 1'b1;
  endtask

  task automatic test_reset_mid();
    hb0_run = 1'b0;
    accept(1'b0, 1'b1, 1'b1);
    repeat (8) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ce0, s0, ce1, s1, cur_sel, req_if.busy, req_if.req_ready} !== 7'b1100001) begin
      errors++;
      $display("FAIL reset_mid: got ce0s0ce1s1cur,busy,ready=%b expected 1100001",
               {ce0, s0, ce1, s1, cur_sel, req_if.busy, req_if.req_ready});
    end
    sb.delete();
    n_accept--;
    model_cur = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) tick();
    hb1_run = 1'b1;
    accept(1'b1, 1'b0, 1'b1);
    wait_done("reset_mid_next", 100);
    checks++;
    if (cur_sel !== 1'b1 || req_if.done_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: got cur=%b err=%b expected 1 0", cur_sel, req_if.done_err);
    end
    tick();
    model_cur = 1'b1;
  endtask

  task automatic test_back_to_back();
    int start_done = n_done;
    int start_acc = n_accept;
    int n;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      n = 0;
      while (req_if.req_ready !== 1'b1 && n < 400) begin
        tick();
        n++;
      end
      checks++;
      if (req_if.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: got ready=%b after %0d cycles expected 1", req_if.req_ready, n);
      end
      req_if.req_sel   = 1'($urandom_range(0, 1));
      hb0_run          = 1'($urandom_range(0, 1));
      hb1_run          = 1'($urandom_range(0, 1));
      req_if.req_valid = 1'b1;
      tick();
      e.sel = model_cur;
      e.err = 1'b0;
      if (req_if.req_sel != model_cur) begin
        if ((req_if.req_sel ? hb1_run : hb0_run) == 1'b1) begin
          e.sel = req_if.req_sel;
        end else begin
          e.err = 1'b1;
        end
      end
      model_cur = e.sel;
      sb.push_back(e);
      n_accept++;
    end
    req_if.req_valid = 1'b0;
    n = 0;
    while ((req_if.req_ready !== 1'b1 || sb.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if ((n_done - start_done) != (n_accept - start_acc) || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones (%0d pending) expected %0d",
               n_done - start_done, sb.size(), n_accept - start_acc);
    end
  endtask

  initial begin
    test_reset();
    test_same_sel();
    test_timeout();
    test_switch();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
